// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer
// Sequences commands from the HPS over the 32-bit PIO pair. Each command is
// either handled internally (NOP, QUERY, illegal opcode) or handed to the
// FPGA-side engine over a valid/ready handshake. The coded response is shown
// on hps_resp with hps_status high until the HPS drops req.
// Optional build macro: PIO_CMD_TIMEOUT_EN adds an engine watchdog that
// aborts a stuck command after TIMEOUT_CYC cycles.
`timescale 1ns/1ps

module pio_cmd_sequencer #(
    parameter logic [7:0] VALID_OP_MASK = 8'b0011_1111,
    parameter int         TIMEOUT_CYC   = 1000000,
    parameter int         CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hps_cmd,
    output logic [31:0] hps_resp,
    output logic        hps_status,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic [2:0]  eng_opcode,
    output logic [27:0] eng_payload,
    input  logic        eng_done,
    input  logic [29:0] eng_result,
    output logic        eng_abort,
    output logic        busy
);

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_QUERY     = 3'd6;
    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND,
        WAIT_ACK
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             armed;
    logic [CNT_W-1:0] counter;
    logic [1:0]       pend_code;
    logic [1:0]       pend_code_next;
    logic [29:0]      pend_result;
    logic [29:0]      pend_result_next;
    logic             latch_cmd;
    logic             load_pend;

    logic             req;
    logic [2:0]       cmd_op;
    logic [27:0]      cmd_payload;
    logic             op_legal;

    assign req         = hps_cmd[31];
    assign cmd_op      = hps_cmd[30:28];
    assign cmd_payload = hps_cmd[27:0];
    assign op_legal    = VALID_OP_MASK[cmd_op] || (cmd_op == OP_NOP) || (cmd_op == OP_QUERY);

`ifdef PIO_CMD_TIMEOUT_EN
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    logic [31:0] timer;
    logic        expire;
    logic        complete;

    assign complete = ((state == ISSUE) && eng_ready && eng_done) ||
                      ((state == WAIT_DONE) && eng_done);
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Next-state decode plus the strobes that load the command and pending response
    always_comb begin
        next_state       = state;
        latch_cmd        = 1'b0;
        load_pend        = 1'b0;
        pend_code_next   = CODE_OK;
        pend_result_next = '0;
`ifdef PIO_CMD_TIMEOUT_EN
        expire           = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (armed && req) begin
                    latch_cmd = 1'b1;
                    if (!op_legal) begin
                        next_state     = RESPOND;
                        load_pend      = 1'b1;
                        pend_code_next = CODE_ILLEGAL;
                    end else if (cmd_op == OP_NOP) begin
                        next_state = RESPOND;
                        load_pend  = 1'b1;
                    end else if (cmd_op == OP_QUERY) begin
                        next_state       = RESPOND;
                        load_pend        = 1'b1;
                        pend_result_next = 30'(counter);
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (eng_ready) begin
                    if (eng_done) begin
                        next_state       = RESPOND;
                        load_pend        = 1'b1;
                        pend_result_next = eng_result;
                    end else begin
                        next_state = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    next_state       = RESPOND;
                    load_pend        = 1'b1;
                    pend_result_next = eng_result;
                end
            end
            RESPOND: begin
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
`ifdef PIO_CMD_TIMEOUT_EN
        if (((state == ISSUE) || (state == WAIT_DONE)) &&
            (timer == 32'(TIMEOUT_CYC - 1)) && !complete) begin
            expire           = 1'b1;
            next_state       = RESPOND;
            load_pend        = 1'b1;
            pend_code_next   = CODE_TIMEOUT;
            pend_result_next = '0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs, arming flag, pending response and completed-command counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hps_resp    <= '0;
            hps_status  <= 1'b0;
            eng_valid   <= 1'b0;
            eng_opcode  <= '0;
            eng_payload <= '0;
            busy        <= 1'b0;
            armed       <= 1'b0;
            counter     <= '0;
            pend_code   <= CODE_OK;
            pend_result <= '0;
        end else begin
            if (!req) begin
                armed <= 1'b1;
            end
            if (latch_cmd) begin
                eng_opcode  <= cmd_op;
                eng_payload <= cmd_payload;
            end
            if (load_pend) begin
                pend_code   <= pend_code_next;
                pend_result <= pend_result_next;
            end
            eng_valid <= (next_state == ISSUE);
            busy      <= (next_state != IDLE);
            if (state == RESPOND) begin
                hps_resp   <= {pend_code, pend_result};
                hps_status <= 1'b1;
                if (pend_code == CODE_OK) begin
                    counter <= counter + CNT_W'(1);
                end
            end
            if ((state == WAIT_ACK) && !req) begin
                hps_status <= 1'b0;
            end
        end
    end

`ifdef PIO_CMD_TIMEOUT_EN
    // Engine watchdog timer and the one-cycle abort pulse on expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            eng_abort <= 1'b0;
        end else begin
            eng_abort <= expire;
            if ((state == IDLE) && (next_state == ISSUE)) begin
                timer <= '0;
            end else if ((state == ISSUE) || (state == WAIT_DONE)) begin
                timer <= timer + 32'd1;
            end
        end
    end
`else
    assign eng_abort = 1'b0;
`endif

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// tb_pio_cmd_sequencer
// Directed bench for pio_cmd_sequencer. Expected response words are queued
// when a command is driven and popped when hps_status rises. Build with
// PIO_CMD_TIMEOUT_EN defined to exercise the watchdog path.
`timescale 1ns/1ps

module tb_pio_cmd_sequencer;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hps_cmd = 32'h8000_0000;
    logic [31:0] hps_resp;
    logic        hps_status;
    logic        eng_valid;
    logic        eng_ready = 1'b0;
    logic [2:0]  eng_opcode;
    logic [27:0] eng_payload;
    logic        eng_done = 1'b0;
    logic [29:0] eng_result = '0;
    logic        eng_abort;
    logic        busy;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_count = 0;
    int          abort_seen = 0;

    pio_cmd_sequencer #(
        .VALID_OP_MASK(8'b0011_1111),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hps_cmd    (hps_cmd),
        .hps_resp   (hps_resp),
        .hps_status (hps_status),
        .eng_valid  (eng_valid),
        .eng_ready  (eng_ready),
        .eng_opcode (eng_opcode),
        .eng_payload(eng_payload),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .eng_abort  (eng_abort),
        .busy       (busy)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=stalled expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] expected);
        hps_cmd = cmd;
        exp_q.push_back(expected);
    endtask

    task automatic resetDut();
        reset   = 1'b1;
        hps_cmd = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        exp_count = 0;
    endtask

    task automatic collectResponse(input string tag);
        int          n;
        logic [31:0] exp_val;
        n = 0;
        while (hps_status !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checkOutput({tag, "_status"}, {31'd0, hps_status}, 32'd1);
        exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checkOutput({tag, "_resp"}, hps_resp, exp_val);
        hps_cmd[31] = 1'b0;
        tick();
        checkOutput({tag, "_clear"}, {30'd0, hps_status, busy}, 32'd0);
    endtask

    task automatic nopCmd(input string tag);
        applyStimulus(32'h8000_0000, 32'h0);
        collectResponse(tag);
        exp_count++;
    endtask

    task automatic queryCmd(input string tag);
        applyStimulus(32'hE000_0000, 32'(exp_count % (1 << CNT_W)));
        collectResponse(tag);
        exp_count++;
    endtask

    task automatic engineOp(input string tag, input logic [27:0] payload, input logic [29:0] result,
                            input int ready_delay, input int done_delay);
        applyStimulus({1'b1, 3'd1, payload}, {2'b00, result});
        tick();
        repeat (ready_delay) tick();
        eng_ready = 1'b1;
        if (done_delay == 0) begin
            eng_done   = 1'b1;
            eng_result = result;
        end
        tick();
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        if (done_delay > 0) begin
            repeat (done_delay - 1) tick();
            eng_done   = 1'b1;
            eng_result = result;
            tick();
            eng_done = 1'b0;
        end
        collectResponse(tag);
        exp_count++;
    endtask

    // Directed sequence
    initial begin
        // Reset with a stale req held high
        tick();
        checkOutput("reset_resp", hps_resp, 32'h0);
        checkOutput("reset_ctl", {25'd0, hps_status, eng_valid, eng_abort, busy, eng_opcode}, 32'h0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("stale_req", {29'd0, hps_status, eng_valid, busy}, 32'h0);
        hps_cmd = 32'h0;
        tick();

        // NOP latency: status two edges after req is sampled
        applyStimulus(32'h8000_0000, 32'h0);
        tick();
        checkOutput("nop_lat1", {31'd0, hps_status}, 32'd0);
        tick();
        checkOutput("nop_lat2", {31'd0, hps_status}, 32'd1);
        collectResponse("nop");
        exp_count++;

        // Engine op with delayed ready and late done
        applyStimulus(32'h9000_0ABC, 32'h0123_4567);
        tick();
        checkOutput("issue_valid", {31'd0, eng_valid}, 32'd1);
        checkOutput("issue_cmd", {1'b0, eng_opcode, eng_payload}, 32'h1000_0ABC);
        repeat (3) tick();
        checkOutput("issue_hold", {31'd0, eng_valid}, 32'd1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        checkOutput("accept_drop", {31'd0, eng_valid}, 32'd0);
        hps_cmd = 32'h9FFF_FFFF;
        repeat (4) tick();
        checkOutput("payload_stable", {4'd0, eng_payload}, 32'h0000_0ABC);
        eng_done   = 1'b1;
        eng_result = 30'h0123_4567;
        tick();
        eng_done = 1'b0;
        repeat (3) tick();
        checkOutput("ack_hold", {31'd0, hps_status}, 32'd1);
        collectResponse("eng_slow");
        exp_count++;

        // Engine op with immediate ready and done: status three edges after req
        applyStimulus(32'h9000_0001, 32'h2AAA_AAAA);
        tick();
        eng_ready  = 1'b1;
        eng_done   = 1'b1;
        eng_result = 30'h2AAA_AAAA;
        tick();
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        checkOutput("fast_lat2", {31'd0, hps_status}, 32'd0);
        tick();
        checkOutput("fast_lat3", {31'd0, hps_status}, 32'd1);
        collectResponse("eng_fast");
        exp_count++;

        // Illegal opcode 7 never reaches the engine
        applyStimulus(32'hF000_0000, 32'h4000_0000);
        tick();
        checkOutput("illegal_busy", {30'd0, eng_valid, busy}, 32'd1);
        tick();
        checkOutput("illegal_novalid", {31'd0, eng_valid}, 32'd0);
        collectResponse("illegal");

        // Counter: three successes then QUERY, then wrap through zero
        resetDut();
        tick();
        engineOp("cnt_a", 28'h0000001, 30'h0000011, 0, 1);
        engineOp("cnt_b", 28'h0000002, 30'h0000022, 2, 0);
        engineOp("cnt_c", 28'h0000003, 30'h0000033, 1, 3);
        queryCmd("query3");
        for (int i = 0; i < 11; i++) begin
            nopCmd("fill");
        end
        engineOp("cnt_wrap", 28'h0000004, 30'h0000044, 0, 2);
        queryCmd("query_wrap");

`ifdef PIO_CMD_TIMEOUT_EN
        // Engine never completes: one abort pulse and a timeout response
        applyStimulus(32'hA000_0055, 32'h8000_0000);
        eng_ready  = 1'b1;
        abort_seen = 0;
        for (int n = 0; n < 64 && hps_status !== 1'b1; n++) begin
            tick();
            if (eng_abort === 1'b1) abort_seen++;
        end
        eng_ready = 1'b0;
        repeat (2) begin
            tick();
            if (eng_abort === 1'b1) abort_seen++;
        end
        checkOutput("abort_once", 32'(abort_seen), 32'd1);
        collectResponse("timeout");
        queryCmd("query_after_timeout");
`else
        // Engine never completes: controller waits with no abort
        hps_cmd    = 32'hA000_0055;
        eng_ready  = 1'b1;
        abort_seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (eng_abort === 1'b1) abort_seen++;
        end
        eng_ready = 1'b0;
        checkOutput("wait_busy", {31'd0, busy}, 32'd1);
        checkOutput("no_abort", 32'(abort_seen), 32'd0);
        resetDut();
        tick();
`endif

        // Reset while waiting for done, then a stale done pulse
        hps_cmd = 32'h9000_0777;
        tick();
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        tick();
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset   = 1'b1;
        hps_cmd = 32'h0;
        tick();
        checkOutput("mid_reset_ctl", {25'd0, hps_status, eng_valid, eng_abort, busy, eng_opcode}, 32'h0);
        checkOutput("mid_reset_payload", {4'd0, eng_payload}, 32'h0);
        checkOutput("mid_reset_resp", hps_resp, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        exp_count = 0;
        tick();
        eng_done   = 1'b1;
        eng_result = 30'h3FFF_FFFF;
        tick();
        eng_done = 1'b0;
        tick();
        checkOutput("stale_done", {29'd0, hps_status, eng_valid, busy}, 32'h0);
        engineOp("post_reset", 28'h0000123, 30'h000BEEF, 1, 2);
        queryCmd("query_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
